// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the ALU: valid/ready capture,
// ALU code decode, EX/MEM and MEM/WB forwarding, load-use stall and flush.
module id_ex_stage #(
  parameter int WIDTH = 64,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [1:0]       ALUOp,
  input  logic [2:0]       Funct3,
  input  logic             Funct7b5,
  input  logic             ALUSrc,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             Branch,
  input  logic [REGW-1:0]  Rs1,
  input  logic [REGW-1:0]  Rs2,
  input  logic [REGW-1:0]  Rd,
  input  logic             UsesRs2,
  input  logic [WIDTH-1:0] RegData1,
  input  logic [WIDTH-1:0] RegData2,
  input  logic [WIDTH-1:0] Imm,
  input  logic             ExMemRegWrite,
  input  logic [REGW-1:0]  ExMemRd,
  input  logic [WIDTH-1:0] ExMemResult,
  input  logic             MemWbRegWrite,
  input  logic [REGW-1:0]  MemWbRd,
  input  logic [WIDTH-1:0] MemWbData,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] StoreData,
  output logic [3:0]       Operation,
  output logic [REGW-1:0]  RdOut,
  output logic             RegWriteOut,
  output logic             MemReadOut,
  output logic             MemWriteOut,
  output logic             BranchOut,
  output logic             IllegalOp
);

  logic             valid_q;
  logic [3:0]       op_q, op_d;
  logic             ill_q, ill_d;
  logic [REGW-1:0]  rd_q, rs1_q, rs2_q;
  logic [WIDTH-1:0] rd1_q, rd2_q, imm_q;
  logic             alusrc_q;
  logic             rw_q, mr_q, mw_q, br_q;
  logic             hazard, capture;
  logic [WIDTH-1:0] fwd1, fwd2;

  always_comb begin
    op_d  = 4'b0010;
    ill_d = 1'b0;
    case (ALUOp)
      2'b00: op_d = 4'b0010;
      2'b01: op_d = 4'b0110;
      default: begin
        case (Funct3)
          3'b000: begin
            if (ALUOp == 2'b10 && Funct7b5)
              op_d = 4'b0110;
            else
              op_d = 4'b0010;
          end
          3'b111: op_d = 4'b0000;
          3'b110: op_d = 4'b0001;
          3'b010: op_d = 4'b0111;
          default: ill_d = 1'b1;
        endcase
      end
    endcase
  end

  // EX/MEM is the younger result, so it wins over MEM/WB
  always_comb begin
    if (ExMemRegWrite && ExMemRd != '0 && ExMemRd == rs1_q)
      fwd1 = ExMemResult;
    else if (MemWbRegWrite && MemWbRd != '0 && MemWbRd == rs1_q)
      fwd1 = MemWbData;
    else
      fwd1 = rd1_q;
  end

  always_comb begin
    if (ExMemRegWrite && ExMemRd != '0 && ExMemRd == rs2_q)
      fwd2 = ExMemResult;
    else if (MemWbRegWrite && MemWbRd != '0 && MemWbRd == rs2_q)
      fwd2 = MemWbData;
    else
      fwd2 = rd2_q;
  end

  assign hazard = valid_q && mr_q && rd_q != '0 && InValid &&
                  (Rs1 == rd_q || (UsesRs2 && Rs2 == rd_q));

  assign InReady = !reset && !Flush && !hazard &&
                   (!valid_q || OutReady);
  assign capture = InValid && InReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      op_q     <= 4'b0010;
      ill_q    <= 1'b0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      alusrc_q <= 1'b0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      br_q     <= 1'b0;
    end else if (Flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q  <= 1'b1;
      op_q     <= op_d;
      ill_q    <= ill_d;
      rd_q     <= Rd;
      rs1_q    <= Rs1;
      rs2_q    <= Rs2;
      rd1_q    <= RegData1;
      rd2_q    <= RegData2;
      imm_q    <= Imm;
      alusrc_q <= ALUSrc;
      rw_q     <= RegWrite;
      mr_q     <= MemRead;
      mw_q     <= MemWrite;
      br_q     <= Branch;
    end else if (OutReady && valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign OutValid    = valid_q;
  assign A           = fwd1;
  assign StoreData   = fwd2;
  assign B           = alusrc_q ? imm_q : fwd2;
  assign Operation   = op_q;
  assign IllegalOp   = ill_q;
  assign RdOut       = rd_q;
  assign RegWriteOut = rw_q;
  assign MemReadOut  = mr_q;
  assign MemWriteOut = mw_q;
  assign BranchOut   = br_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the 64-bit ALU. It captures a decoded instruction and its register-file operands with a valid/ready handshake, and registers the 4-bit ALU Operation code. It resolves EX/MEM and MEM/WB forwarding combinationally onto the ALU A/B inputs. It also detects load-use hazards, stalls decode for one bubble, and supports a branch flush.

## Interface
- WIDTH, 64, datapath width; A, B and StoreData widths.
- REGW, 5, register address width.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- InValid  in  1  decode presents an instruction.
- InReady  out  1  stage accepts this cycle.
- ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type arith.
- Funct3  in  3  instruction[14:12].
- Funct7b5  in  1  instruction[30].
- ALUSrc  in  1  B takes Imm when 1.
- RegWrite, MemRead, MemWrite, Branch  in  1 each  control bits.
- Rs1, Rs2, Rd  in  REGW each  register addresses.
- UsesRs2  in  1  instruction reads Rs2 (R-type, store, branch).
- RegData1, RegData2, Imm  in  WIDTH each  operands.
- ExMemRegWrite  in  1  EX/MEM forward source enable.
- ExMemRd  in  REGW  EX/MEM forward source address.
- ExMemResult  in  WIDTH  EX/MEM forward source data.
- MemWbRegWrite  in  1  MEM/WB forward source enable.
- MemWbRd  in  REGW  MEM/WB forward source address.
- MemWbData  in  WIDTH  MEM/WB forward source data.
- Flush  in  1  kill resident and incoming instruction.
- OutValid  out  1  stage holds a live instruction.
- OutReady  in  1  EX consumes this cycle.
- A, B, StoreData  out  WIDTH  ALU operands and store data.
- Operation  out  4  ALU code: {Ainvert, Binvert, Op[1:0]}.
- RdOut  out  REGW  destination register.
- RegWriteOut, MemReadOut, MemWriteOut, BranchOut, IllegalOp  out  1 each  registered controls.

## Operation
- Capture fires when InValid && InReady.
  - On capture, all fields are registered.
  - Operation and IllegalOp are decoded at capture.
- Operation decode:
  - ALUOp 00 → 0010 (add).
  - ALUOp 01 → 0110 (sub).
  - ALUOp 10, Funct3 000 → 0010 if Funct7b5=0, else 0110.
  - ALUOp 10/11, Funct3 111 → 0000 (and).
  - ALUOp 10/11, Funct3 110 → 0001 (or).
  - ALUOp 10/11, Funct3 010 → 0111 (slt).
  - ALUOp 11, Funct3 000 → 0010 regardless of Funct7b5.
  - Any other ALUOp 10/11 combination → Operation 0010, IllegalOp=1.
- Forwarding (combinational, from registered Rs1/Rs2), applied per operand:
  - ExMem source when ExMemRegWrite && ExMemRd!=0 && ExMemRd==Rs.
  - Otherwise MemWb source when MemWbRegWrite && MemWbRd!=0 && MemWbRd==Rs.
  - Otherwise the registered RegData.
- Operand selection:
  - A = forwarded rs1.
  - StoreData = forwarded rs2.
  - B = ALUSrc ? Imm : forwarded rs2.
- Load-use hazard is asserted when all of the following hold:
  - OutValid && MemReadOut && RdOut!=0;
  - InValid;
  - Rs1==RdOut, or (UsesRs2 && Rs2==RdOut).
- InReady = !reset && !Flush && !hazard && (!OutValid || OutReady).
- Register update per edge, in priority order:
  - reset: OutValid←0.
  - Flush: OutValid←0; incoming instruction is dropped.
  - capture: OutValid←1.
  - OutReady && OutValid with no capture: OutValid←0.
  - otherwise: hold all registers.
- Rd=0 destinations are legal and never forward.

## Timing
- Reset values:
  - OutValid, InReady, IllegalOp = 0.
  - All control outputs = 0.
  - Operation = 0010.
  - RdOut = 0.
  - All data registers = 0.
- Latency: an instruction captured at edge n is presented with OutValid=1 from cycle n+1.
- Full throughput: one instruction per cycle when OutReady=1 and no hazard.
- Backpressure: while OutValid && !OutReady, registered state holds and InReady=0. A and B still track the forwarding inputs.
- Load-use:
  - Stall while the load is resident.
  - The load fires at edge t; the stage is empty in cycle t+1 (bubble).
  - InReady=1 in cycle t+1; the dependent is captured at the t+1 edge.
  - In cycle t+2 the dependent's operand comes from MemWbData.
- Flush with InValid=1: nothing is captured; OutValid=0 next cycle.
- Reset during a stall drops both instructions.

## Test plan
- Back-to-back R-type, OutReady=1: add (F3=000, F7b5=0) then sub (F3=000, F7b5=1) then slt (F3=010). Expect Operation 0010, 0110, 0111 on consecutive cycles, OutValid constant 1.
- Forward priority: Rs1=5, ExMemRd=5 with ExMemResult=0x11, MemWbRd=5 with MemWbData=0x22, both RegWrite=1. Expect A=0x11. Then drop ExMemRegWrite and expect A=0x22. Then ExMemRd=MemWbRd=0 and expect A=RegData1.
- Load-use: ld x3 then add x4,x3,x1 with OutReady=1. Expect InReady=0 in the load cycle and OutValid=0 for exactly one cycle. The add then presents A=MemWbData (0xDEAD) from MemWbRd=3.
- Backpressure: OutReady=0 for 3 cycles with InValid=1. Expect InReady=0 and outputs stable throughout; the next instruction is captured the edge after OutReady rises.
- Flush: Flush=1 with a resident instruction and InValid=1. Expect OutValid=0 next cycle and the incoming instruction never appears.
- Illegal and immediate: ALUOp=10, F3=001 → IllegalOp=1, Operation=0010. ALUOp=11, F3=000, F7b5=1, ALUSrc=1, Imm=-4 → Operation=0010, B=0xFFFFFFFFFFFFFFFC.
